// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and unloader state type for the AES byte unloader
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_BYTES   = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } unload_state_t;

endpackage

// File: rtl/aes_byte_counter.sv
// rtl/aes_byte_counter.sv - mod-MOD word counter with increment, clear and terminal count
module aes_byte_counter #(
    parameter int MOD = 16,
    parameter int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment so a reload on the last word restarts at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/aes_block_unloader.sv
// rtl/aes_block_unloader.sv - N-bit block to W-bit MSB-first stream; AES_UNLOAD_LAST_EN adds out_last
module aes_block_unloader
    import aes_pkg::*;
#(
    parameter int N = AES_BLOCK_W,
    parameter int W = AES_BYTE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_UNLOAD_LAST_EN
    output logic         out_last,
`endif
    output logic [W-1:0] out_data
);

    localparam int WORDS = N / W;

    unload_state_t state_q;
    unload_state_t state_d;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_d;
    logic          last_word;
    logic          advance;
    logic          load;

    // The block accepts a new input only when idle or while the last word leaves,
    // which keeps back-to-back blocks bubble-free
    assign in_ready  = (state_q == IDLE) || ((state_q == SHIFT) && last_word && out_ready);
    assign load      = in_valid && in_ready;
    assign advance   = (state_q == SHIFT) && out_ready;
    assign out_valid = (state_q == SHIFT);
    assign out_data  = shift_q[N-1 -: W];

`ifdef AES_UNLOAD_LAST_EN
    assign out_last  = (state_q == SHIFT) && last_word;
`endif

    aes_byte_counter #(
        .MOD (WORDS)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (advance),
        .clear_i (load),
        .tc_o    (last_word)
    );

    // Next state: load a block, shift one word per accepted transfer, return idle after the last
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        if (load) begin
            shift_d = in_data;
            state_d = SHIFT;
        end else if (advance) begin
            shift_d = shift_q << W;
            if (last_word) begin
                state_d = IDLE;
            end
        end
    end

    // State and shift register, synchronous active-high reset drops any block in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_aes_block_unloader.sv
// tb/tb_aes_block_unloader.sv - scoreboard bench for aes_block_unloader
module tb_aes_block_unloader;
    import aes_pkg::*;

    localparam int N     = AES_BLOCK_W;
    localparam int W     = AES_BYTE_W;
    localparam int WORDS = N / W;

    localparam logic [127:0] B1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] B4 = 128'hdeadbeefcafef00d0123456789abcdef;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef AES_UNLOAD_LAST_EN
    logic         out_last;
`endif

    aes_block_unloader #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AES_UNLOAD_LAST_EN
        .out_last  (out_last),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: each accepted block becomes WORDS queued {last, byte} entries, MSB byte first
    logic [8:0]   sb[$];
    logic [8:0]   popped;
    logic [127:0] blk;
    bit           armed     = 0;
    bit           prev_rst  = 0;
    bit           prev_stall = 0;
    logic [7:0]   prev_data;
    bit           exp_ready;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            armed      = 1;
            prev_rst   = 1;
            prev_stall = 0;
        end else if (armed) begin
            exp_ready = (sb.size() == 0) || (sb.size() == 1 && out_ready);
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (prev_rst) chk("reset_out_data", 32'(out_data), 32'(0));
            if (prev_stall) chk("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
            if (out_valid && sb.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(sb[0][7:0]));
`ifdef AES_UNLOAD_LAST_EN
                chk("out_last", 32'(out_last), 32'(sb[0][8]));
`endif
            end
`ifdef AES_UNLOAD_LAST_EN
            if (!out_valid) chk("out_last_idle", 32'(out_last), 32'(0));
`endif
            if (out_valid && out_ready && sb.size() != 0) popped = sb.pop_front();
            if (in_valid && exp_ready) begin
                for (int i = 0; i < WORDS; i++) begin
                    blk = in_data >> (8 * (WORDS - 1 - i));
                    sb.push_back({(i == WORDS - 1), blk[7:0]});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_rst   = 0;
        end
    end

    // Downstream ready generator: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    int ready_mode = 0;
    int ready_ph   = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_ph % 3 == 0);
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        ready_ph++;
    end

    task automatic send(input logic [127:0] d);
        bit hs;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) return;
        end
        timeout("send_handshake");
    endtask

    task automatic drain();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid && sb.size() == 0) return;
        end
        timeout("drain");
    endtask

    time t0;
    time t1;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single block, always ready
        send(B1);
        in_valid = 1'b0;
        drain();

        // backpressure
        ready_mode = 1;
        send(B1);
        in_valid = 1'b0;
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // back-to-back: 32 bytes in 32 cycles
        send(B1);
        t0 = $time;
        send(B2);
        in_valid = 1'b0;
        drain();
        t1 = $time;
        chk("b2b_cycles", 32'((t1 - t0) / 10), 32'(2 * WORDS));

        // busy input ignored mid-stream
        send(B3);
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = B4;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        drain();

        // reset mid-block
        send(B1);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_reset_valid", 32'(out_valid), 32'(0));
        chk("post_reset_ready", 32'(in_ready), 32'(1));
        send(B2);
        in_valid = 1'b0;
        drain();

        // randomized blocks, random backpressure and gaps
        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            send({$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        drain();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
